// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: redirect, instruction-memory request/response and decode-side
// channels of the fetch queue. master = environment, slave = ifetch_queue.
interface ifetch_queue_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    modport master (
        output redirect_valid, redirect_pc, imem_req_ready,
               imem_resp_valid, imem_resp_data, out_ready,
        input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr
    );

    modport slave (
        input  redirect_valid, redirect_pc, imem_req_ready,
               imem_resp_valid, imem_resp_data, out_ready,
        output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr
    );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: in-order instruction fetch front end. Issues sequential fetch
// requests, buffers PC-tagged responses in a DEPTH-entry queue and drains them
// to decode. A redirect flushes the queue and drops responses still in flight.
// Optional IFETCH_PERF_CNT_EN adds saturating drop/starve event counters.
module ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    ifetch_queue_if.slave    bus
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]      perf_drop_cnt,
    output logic [31:0]      perf_starve_cnt
`endif
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
    localparam logic [PW:0]   DEPTH_P1 = (PW+1)'(DEPTH);

    logic [PW-1:0]    head_q;
    logic [PW-1:0]    fill_q;
    logic [PW-1:0]    tail_q;
    logic [PW-1:0]    drop_q;
    logic [31:0]      fetch_pc_q;
    logic [31:0]      pc_q    [DEPTH];
    logic [31:0]      instr_q [DEPTH];
    logic [DEPTH-1:0] filled_q;

    logic [PW-1:0]    occupancy_c;
    logic [PW-1:0]    inflight_c;
    logic [PW:0]      pending_c;
    logic [AW-1:0]    head_idx_c;
    logic [AW-1:0]    fill_idx_c;
    logic [AW-1:0]    tail_idx_c;
    logic             req_fire_c;
    logic             pop_c;
    logic             resp_err_c;
    logic             resp_drop_c;
    logic             resp_take_c;

    // Request gating, head read and handshake decode
    always_comb begin
        occupancy_c = tail_q - head_q;
        inflight_c  = tail_q - fill_q;
        pending_c   = {1'b0, drop_q} + {1'b0, inflight_c};
        head_idx_c  = head_q[AW-1:0];
        fill_idx_c  = fill_q[AW-1:0];
        tail_idx_c  = tail_q[AW-1:0];

        bus.imem_req_valid = !rst && !bus.redirect_valid
                             && (occupancy_c < DEPTH_P) && (pending_c < DEPTH_P1);
        bus.imem_req_addr  = fetch_pc_q;
        bus.out_valid      = filled_q[head_idx_c] && !bus.redirect_valid;
        bus.out_pc         = pc_q[head_idx_c];
        bus.out_instr      = instr_q[head_idx_c];

        req_fire_c  = bus.imem_req_valid && bus.imem_req_ready;
        pop_c       = bus.out_valid && bus.out_ready;
        resp_err_c  = bus.imem_resp_valid && (drop_q == '0) && (fill_q == tail_q);
        resp_drop_c = bus.imem_resp_valid && (drop_q != '0);
        resp_take_c = bus.imem_resp_valid && (drop_q == '0) && (fill_q != tail_q);
    end

    // Queue pointers, entry storage, fetch PC and stale-response counter
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            fill_q     <= '0;
            tail_q     <= '0;
            drop_q     <= '0;
            fetch_pc_q <= RESET_PC;
            filled_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else if (bus.redirect_valid) begin
            // Everything in flight becomes stale; this cycle's response is dropped too
            drop_q     <= drop_q + inflight_c - PW'(bus.imem_resp_valid && !resp_err_c);
            head_q     <= '0;
            fill_q     <= '0;
            tail_q     <= '0;
            filled_q   <= '0;
            fetch_pc_q <= bus.redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (req_fire_c) begin
                pc_q[tail_idx_c]     <= fetch_pc_q;
                filled_q[tail_idx_c] <= 1'b0;
                tail_q               <= tail_q + PW'(1);
                fetch_pc_q           <= fetch_pc_q + 32'd4;
            end
            if (pop_c) begin
                filled_q[head_idx_c] <= 1'b0;
                head_q               <= head_q + PW'(1);
            end
            if (resp_drop_c) begin
                drop_q <= drop_q - PW'(1);
            end
            if (resp_take_c) begin
                instr_q[fill_idx_c]  <= bus.imem_resp_data;
                filled_q[fill_idx_c] <= 1'b1;
                fill_q               <= fill_q + PW'(1);
            end
        end
        if (!rst) begin
            assert (!resp_err_c)
                else $error("ifetch_queue: response received with no request outstanding");
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    // Saturating counters of discarded responses and decode-starved cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_drop_cnt   <= '0;
            perf_starve_cnt <= '0;
        end else begin
            if (bus.imem_resp_valid && !resp_err_c && (bus.redirect_valid || (drop_q != '0))
                && (perf_drop_cnt != 32'hFFFF_FFFF)) begin
                perf_drop_cnt <= perf_drop_cnt + 32'd1;
            end
            if (bus.out_ready && !bus.out_valid && !bus.redirect_valid
                && (perf_starve_cnt != 32'hFFFF_FFFF)) begin
                perf_starve_cnt <= perf_starve_cnt + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: randomized bench for ifetch_queue. A transaction-level model
// (pending-request list tagged by redirect epoch, queue of deliverable PCs)
// predicts every output each cycle; directed phases pin the model to literals.
module tb_ifetch_queue;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ifetch_queue_if bus();
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_drop_cnt;
    logic [31:0] perf_starve_cnt;
`endif

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_drop_cnt   (perf_drop_cnt),
        .perf_starve_cnt (perf_starve_cnt)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          ep;
        int          due;
    } req_t;

    req_t        pend[$];       // requests sent to memory, response not yet returned
    logic [31:0] mq[$];         // PCs whose instruction is deliverable to decode
    logic [31:0] fpc;
    int          epoch;
    int          cyc;
    int          last_due;
    int          m_drops;
    int          m_starves;
    int          n_checks;
    int          n_fail;
    int unsigned k_rr, k_or, k_lat_lo, k_lat_hi, k_redir;
    logic        force_redir;
    logic [31:0] force_pc;
    logic [31:0] req_log[$];
    logic [31:0] pop_log[$];
    logic [31:0] pop_ilog[$];
    logic [31:0] pop_cyc[$];
    int          phase_start;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: actual %h required %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic start_phase();
        req_log.delete();
        pop_log.delete();
        pop_ilog.delete();
        pop_cyc.delete();
        phase_start = cyc;
        force_redir = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst                 = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.out_ready       = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_out_pc", bus.out_pc, 32'h0);
        check("rst_out_instr", bus.out_instr, 32'h0);
`ifdef IFETCH_PERF_CNT_EN
        check("rst_perf_drop", perf_drop_cnt, 32'h0);
        check("rst_perf_starve", perf_starve_cnt, 32'h0);
`endif
        pend.delete();
        mq.delete();
        fpc       = 32'h0;
        epoch++;
        last_due  = 0;
        m_drops   = 0;
        m_starves = 0;
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model
    task automatic step();
        int          occ;
        int          due;
        logic        exp_rv, exp_ov, rd, resp_v;
        logic [31:0] rpc;
        @(posedge clk); #1;
        rst = 1'b0;
        rd  = force_redir || ($urandom_range(99, 0) < k_redir);
        if (force_redir)                      rpc = force_pc;
        else if ($urandom_range(3, 0) == 0)   rpc = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
        else                                  rpc = $urandom();
        bus.redirect_valid  = rd;
        bus.redirect_pc     = rpc;
        bus.imem_req_ready  = ($urandom_range(99, 0) < k_rr);
        bus.out_ready       = ($urandom_range(99, 0) < k_or);
        resp_v              = (pend.size() > 0) && (pend[0].due <= cyc);
        bus.imem_resp_valid = resp_v;
        bus.imem_resp_data  = resp_v ? mem_word(pend[0].addr) : $urandom();

        @(negedge clk);
        occ = mq.size();
        foreach (pend[i]) if (pend[i].ep == epoch) occ++;
        exp_rv = !rd && (occ < int'(DEPTH)) && (pend.size() < int'(DEPTH));
        exp_ov = !rd && (mq.size() > 0);
        check("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
        if (exp_rv) check("req_addr", bus.imem_req_addr, fpc);
        check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
        if (exp_ov) begin
            check("out_pc", bus.out_pc, mq[0]);
            check("out_instr", bus.out_instr, mem_word(mq[0]));
        end
`ifdef IFETCH_PERF_CNT_EN
        check("perf_drop", perf_drop_cnt, 32'(m_drops));
        check("perf_starve", perf_starve_cnt, 32'(m_starves));
`endif
        if (bus.imem_req_valid && bus.imem_req_ready) req_log.push_back(bus.imem_req_addr);
        if (bus.out_valid && bus.out_ready) begin
            pop_log.push_back(bus.out_pc);
            pop_ilog.push_back(bus.out_instr);
            pop_cyc.push_back(32'(cyc - phase_start));
        end

        if (resp_v) begin
            if (rd || (pend[0].ep != epoch)) m_drops++;
            else                             mq.push_back(pend[0].addr);
            void'(pend.pop_front());
        end
        if (exp_ov && bus.out_ready) void'(mq.pop_front());
        if (bus.out_ready && !exp_ov && !rd) m_starves++;
        if (exp_rv && bus.imem_req_ready) begin
            due = cyc + int'($urandom_range(k_lat_hi, k_lat_lo));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{fpc, epoch, due});
            fpc = fpc + 32'd4;
        end
        if (rd) begin
            epoch++;
            mq.delete();
            fpc = rpc & 32'hFFFF_FFFC;
        end
        cyc++;
    endtask

    task automatic knobs(input int unsigned rr, input int unsigned ordy, input int unsigned lo,
                         input int unsigned hi, input int unsigned rdp);
        k_rr = rr; k_or = ordy; k_lat_lo = lo; k_lat_hi = hi; k_redir = rdp;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        n_checks = 0; n_fail = 0; cyc = 0; epoch = 0;
        force_redir = 1'b0; force_pc = '0;

        // Streaming with 1-cycle memory: one instruction per cycle after priming
        do_reset();
        knobs(100, 100, 1, 1, 0);
        start_phase();
        repeat (12) step();
        for (int i = 0; i < 3; i++) check("t1_req", qget(req_log, i), 32'(4 * i));
        for (int i = 0; i < 4; i++) begin
            check("t1_pop_pc", qget(pop_log, i), 32'(4 * i));
            check("t1_pop_cyc", qget(pop_cyc, i), 32'(2 + i));
        end
        check("t1_instr0", qget(pop_ilog, 0), 32'h5A5A_0F0F);

        // Decode stalled: queue fills with exactly DEPTH requests, then drains in order
        do_reset();
        knobs(100, 0, 1, 1, 0);
        start_phase();
        repeat (8) step();
        check("t2_nreq_stalled", 32'(req_log.size()), 32'd4);
        k_or = 100;
        repeat (8) step();
        for (int i = 0; i < 4; i++) check("t2_pop_pc", qget(pop_log, i), 32'(4 * i));
        check("t2_req_after", qget(req_log, 4), 32'h10);

        // Redirect with 3 requests in flight on 5-cycle memory; unaligned target
        do_reset();
        knobs(100, 100, 5, 5, 0);
        start_phase();
        force_pc = 32'h0000_0103;
        for (int i = 0; i < 20; i++) begin
            force_redir = (i == 3);
            step();
        end
        force_redir = 1'b0;
        for (int i = 0; i < 3; i++) check("t3_req", qget(req_log, i), 32'(4 * i));
        check("t3_req_redir", qget(req_log, 3), 32'h100);
        check("t3_pop_pc", qget(pop_log, 0), 32'h100);
        check("t3_pop_instr", qget(pop_ilog, 0), mem_word(32'h100));
        check("t3_drops", 32'(m_drops), 32'd3);

        // Redirect coinciding with a response, 2 in flight: two responses dropped in total
        do_reset();
        knobs(100, 100, 2, 2, 0);
        start_phase();
        force_pc = 32'h0000_0200;
        for (int i = 0; i < 12; i++) begin
            force_redir = (i == 2);
            step();
        end
        force_redir = 1'b0;
        check("t4_req_redir", qget(req_log, 2), 32'h200);
        check("t4_pop_pc", qget(pop_log, 0), 32'h200);
        check("t4_drops", 32'(m_drops), 32'd2);

        // Random traffic, latencies, back-pressure and redirects, with a mid-run reset
        do_reset();
        start_phase();
        for (int s = 0; s < 40; s++) begin
            knobs($urandom_range(100, 30), $urandom_range(100, 20), $urandom_range(3, 1),
                  $urandom_range(8, 3), $urandom_range(6, 0));
            if (s == 20) do_reset();
            repeat (100) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- In-order instruction fetch front end that sits directly upstream of the IF/ID pipeline register.
- Owns the sequential fetch PC and issues requests to a variable-latency instruction memory over a valid/ready request channel and a valid-only response channel.
- Buffers returned instructions, each tagged with its PC, in a DEPTH-entry queue; the decode side drains the queue with a valid/ready handshake.
- A redirect (branch prediction or misprediction recovery) flushes the queue and discards any responses still in flight.

Parameters:
DEPTH, 4, number of queue entries and maximum outstanding requests; power of 2, >= 2
RESET_PC, 32'h00000000, fetch address after reset

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
redirect_valid  input  1  discard all fetched/in-flight work, restart fetch at redirect_pc
redirect_pc  input  32  new fetch address; bits [1:0] ignored (treated as 0)
imem_req_valid  output  1  request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  word-aligned fetch address
imem_resp_valid  input  1  response data valid; responses return strictly in request order
imem_resp_data  input  32  instruction word
out_valid  output  1  head entry holds an instruction
out_ready  input  1  decode consumes head
out_pc  output  32  PC of head instruction
out_instr  output  32  head instruction

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - fetch_pc=RESET_PC.
  - head, fill and tail pointers = 0; drop_cnt=0; all filled bits cleared.
  - Outputs: imem_req_valid=0, out_valid=0, out_pc=0, out_instr=0.
- Entry state: each entry holds pc, instr and a filled bit.
  - tail: next entry to allocate. fill: next entry to receive a response. head: oldest entry.
  - Pointers are log2(DEPTH)+1 bits so full and empty are distinguishable.
- Request:
  - imem_req_valid = !rst_cycle && !redirect_valid && (tail-head < DEPTH) && (drop_cnt + (tail-fill) < DEPTH).
  - imem_req_addr = fetch_pc, a registered value.
  - On handshake: entry[tail].pc <= fetch_pc, filled <= 0, tail++, fetch_pc += 4 (32-bit wrap from 0xFFFFFFFC to 0).
  - First request is asserted in the first cycle after rst deasserts.
- Response:
  - If drop_cnt != 0: the response is discarded and drop_cnt decrements.
  - Otherwise: entry[fill].instr <= data, filled <= 1, fill++.
  - A response when drop_cnt==0 and fill==tail is a protocol error; ignore it and raise a simulation assertion.
- Output:
  - out_valid = entry[head].filled && !redirect_valid. out_pc and out_instr are combinational reads of the head entry.
  - Latency: response accepted in cycle t gives out_valid in cycle t+1 at the earliest; there is no bypass.
  - Pop on out_valid && out_ready: clear filled, head++.
  - Pop and response in the same cycle are both honoured; full throughput is 1 instruction/cycle once the queue is primed.
- Redirect (single cycle, highest priority):
  - drop_cnt <= drop_cnt + (tail-fill) - (imem_resp_valid ? 1 : 0). The response arriving in the redirect cycle is always discarded.
  - head = fill = tail <= 0; all filled bits cleared; fetch_pc <= {redirect_pc[31:2],2'b00}.
  - imem_req_valid is forced 0 and out_valid is forced 0 in the redirect cycle, so neither handshake can complete.
  - A new request may issue in the next cycle, subject to the outstanding limit.
  - Back-to-back redirects accumulate drop_cnt correctly.
- Boundaries:
  - Queue full (tail-head==DEPTH): no requests.
  - Queue empty: out_valid=0.
  - The outstanding limit (drop_cnt + inflight <= DEPTH) bounds drop_cnt to log2(DEPTH)+1 bits.
  - rst mid-operation: all state returns to reset values at the next edge; responses arriving later are the environment's responsibility (memory is reset too).

Optional Feature:
- Macro: IFETCH_PERF_CNT_EN.
- Defined:
  - Adds output ports perf_drop_cnt (32) and perf_starve_cnt (32); both reset to 0 and saturate at 0xFFFFFFFF.
  - perf_drop_cnt increments on every discarded response.
  - perf_starve_cnt increments each cycle with out_ready=1 && out_valid=0 && !redirect_valid.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, memory with 1-cycle latency, out_ready=1 -> requests 0x0,0x4,0x8,... on consecutive cycles; out_pc sequence 0x0,0x4,... with 1 instruction/cycle after priming.
- out_ready=0, DEPTH=4 -> exactly 4 requests (0x0..0xC) then imem_req_valid=0; raise out_ready -> pops 0x0..0xC in order, then the request for 0x10 issues.
- 3 requests outstanding on 5-cycle-latency memory, redirect_pc=0x103 -> next request addr 0x100; the 3 stale responses are dropped; first out_pc=0x100 with the instruction returned for 0x100.
- Redirect in the same cycle as imem_resp_valid with 2 in flight -> drop_cnt=1; only the next response is dropped; no stale entry is ever output.
- Random imem_req_ready/imem_resp latency and out_ready with random redirects -> scoreboard: every output (pc, instr) matches the memory model, PCs are consecutive +4 between redirects, and there are no overflow/assertion hits.
- With IFETCH_PERF_CNT_EN defined, redirect with 2 in flight and 4 starved cycles -> perf_drop_cnt=2, perf_starve_cnt=4.
